dram_responder: RTL and testbench
=================================

Name: dram_responder

Overview:
- Responder end of the shared DRAM request interface, driven by the bus arbiter's `w_dram_*` initiator signals.
- Accepts one load or store at a time: request is a level on `le`/`we_t`, with the address, control and write data presented alongside.
- Raises busy while it works and returns formatted load data when busy falls.
- Backs the interface with an internal word array plus configurable latency; used as the DRAM model/controller in simulation and on FPGA.

Parameters:
- WORDS, 65536: depth of backing array in 32-bit words; power of two.
- LAT, 2: extra wait cycles before array access; range 1..255.
- INIT_FILE, "": if non-empty, array is loaded with $readmemh at elaboration.

Ports:
- CLK  in  1  clock, all logic on rising edge
- RST  in  1  synchronous reset, active-high
- w_dram_addr  in  32  byte address
- w_dram_wdata  in  32  store data, right-aligned
- w_dram_ctrl  in  3  [1:0] size (00 byte, 01 half, 10 word, 11 treated as word); [2]=1 zero-extend load
- w_dram_le  in  1  load request (level)
- w_dram_we_t  in  1  store request (level)
- w_dram_odata  out  32  load result, held until next load completes
- w_dram_busy  out  1  transaction in progress
- w_dram_err  out  1  one-cycle error pulse

Behaviour:
- Interface: one clock (CLK); reset RST is synchronous and active-high.
- Reset values: busy=0, odata=0, err=0, state=IDLE. Array contents are not reset.
- Reset mid-transaction: next cycle is IDLE with busy=0. An uncommitted store is discarded; a store commits only in FIN.
- State IDLE: on an edge with le|we_t high, capture addr, wdata, ctrl and op, then go to WAIT. Busy=1 from the next cycle.
- Requests are level-sampled only in IDLE. A request still high in the first IDLE cycle after busy falls starts a new transaction.
- Any le/we_t while busy is ignored, not queued.
- State WAIT: hold for LAT cycles using a down-counter, then go to RD.
- State RD: issue synchronous array read of word `addr[log2(WORDS)+1:2]`. Upper address bits are ignored, so addresses wrap.
- State FIN:
  - Load: extract the lane selected by addr[1:0], little-endian. Sign-extend unless ctrl[2]=1, then register into odata.
  - Store: merge wdata into the read word per size and lane, then write the array.
  - Then go to IDLE.
- Busy is high for exactly LAT+2 cycles per transaction. Odata is valid in the first cycle busy=0.
- Misaligned access (half with addr[0]=1, or word with addr[1:0]!=0):
  - Address is aligned down before use.
  - Access is performed as aligned.
  - err pulses for one cycle, coincident with the first busy=0 cycle.
- le and we_t both high: treated as store; odata unchanged; err pulses.
- Store leaves odata unchanged.

Decomposition:
- Shared header `define.vh` holds:
  - ctrl size codes (DRAM_SZ_B/H/W) and the unsigned bit index;
  - state encodings (IDLE, WAIT, RD, FIN).
- Sub-module `dram_resp_fmt` (combinational):
  - load lane extract/extend;
  - store byte-enable merge;
  - misalign detect.
- Top module holds the FSM, latency counter and array.

Test Plan (LAT=2, so busy is 4 cycles):
- SW 0x10 wdata 0xDEADBEEF ctrl 010, then LW 0x10 -> each transaction busy exactly 4 cycles; odata=0xDEADBEEF when busy falls; err=0.
- From that state: LB 0x13 -> 0xFFFFFFDE; LBU (ctrl 100) 0x13 -> 0x000000DE; LH 0x12 -> 0xFFFFDEAD; LHU 0x12 -> 0x0000DEAD.
- SB 0x11 wdata 0x12345655, then LW 0x10 -> 0xDEAD55EF. SH 0x12 wdata 0xAAAA1234, then LW -> 0x123455EF.
- LW 0x12 -> odata = word at 0x10; err high exactly 1 cycle, coincident with busy falling. Both le and we_t on SW 0x20 wdata 0x1 -> word 0x20 written; err pulses; odata unchanged.
- le pulse to 0x20 in 2nd busy cycle of LW 0x10 -> ignored; busy still 4 cycles and odata from 0x10. Le held high through busy fall -> second transaction starts in the first IDLE cycle.
- RST asserted in WAIT of SW 0x30 wdata 0xFFFFFFFF (prior value 0) -> busy=0 next cycle; a later LW 0x30 returns 0. Access to 0x30+4*WORDS aliases 0x30.

Source files
------------

// File: rtl/dram_responder_pkg.sv
// Shared types and ctrl-field encodings for the DRAM responder slice.
package dram_responder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RD,
    FIN
  } state_t;

  localparam logic [1:0] DRAM_SZ_B = 2'b00;
  localparam logic [1:0] DRAM_SZ_H = 2'b01;
  localparam logic [1:0] DRAM_SZ_W = 2'b10;

  // ctrl bit selecting zero-extension on loads
  localparam int unsigned DRAM_CTRL_UNS = 2;

endpackage

// File: rtl/dram_resp_fmt.sv
// Lane extract/extend for loads, byte-lane merge for stores, misalign detect.
module dram_resp_fmt
  import dram_responder_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  ctrl,
  input  logic [31:0] rword,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word,
  output logic        misalign
);

  logic [1:0]  lane;
  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    lane       = 2'b00;
    b          = '0;
    h          = '0;
    misalign   = 1'b0;
    load_data  = rword;
    store_word = wdata;
    case (ctrl[1:0])
      DRAM_SZ_B: begin
        lane       = addr_lo;
        b          = rword[{lane, 3'b000} +: 8];
        load_data  = ctrl[DRAM_CTRL_UNS] ? {24'b0, b} : {{24{b[7]}}, b};
        store_word = rword;
        store_word[{lane, 3'b000} +: 8] = wdata[7:0];
      end
      DRAM_SZ_H: begin
        // odd half addresses are aligned down to the containing halfword
        lane       = {addr_lo[1], 1'b0};
        misalign   = addr_lo[0];
        h          = rword[{lane, 3'b000} +: 16];
        load_data  = ctrl[DRAM_CTRL_UNS] ? {16'b0, h} : {{16{h[15]}}, h};
        store_word = rword;
        store_word[{lane, 3'b000} +: 16] = wdata[15:0];
      end
      default: begin
        misalign   = |addr_lo;
        load_data  = rword;
        store_word = wdata;
      end
    endcase
  end

endmodule

// File: rtl/dram_responder.sv
// DRAM responder: one load/store at a time, fixed LAT+2 busy window, word array backing.
module dram_responder
  import dram_responder_pkg::*;
#(
  parameter int unsigned WORDS     = 65536,
  parameter int unsigned LAT       = 2,
  parameter string       INIT_FILE = ""
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] w_dram_addr,
  input  logic [31:0] w_dram_wdata,
  input  logic [2:0]  w_dram_ctrl,
  input  logic        w_dram_le,
  input  logic        w_dram_we_t,
  output logic [31:0] w_dram_odata,
  output logic        w_dram_busy,
  output logic        w_dram_err
);

  localparam int unsigned AW     = $clog2(WORDS);
  localparam logic [7:0]  LAT_M1 = 8'(LAT - 1);

  state_t        state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [AW+1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [2:0]    ctrl_q, ctrl_d;
  logic          store_q, store_d;
  logic          both_q, both_d;
  logic [31:0]   odata_q, odata_d;
  logic          err_q, err_d;
  logic [31:0]   rdata_q;

  logic [31:0]   load_data, store_word;
  logic          misalign;
  logic [AW-1:0] idx;
  logic          addr_unused;

  logic [31:0] mem [WORDS];

  // upper address bits fall outside the array and wrap
  assign addr_unused = ^w_dram_addr[31:AW+2];
  assign idx         = addr_q[AW+1:2];

  dram_resp_fmt u_fmt (
    .addr_lo    (addr_q[1:0]),
    .ctrl       (ctrl_q),
    .rword      (rdata_q),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .store_word (store_word),
    .misalign   (misalign)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ctrl_d  = ctrl_q;
    store_d = store_q;
    both_d  = both_q;
    odata_d = odata_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (w_dram_le | w_dram_we_t) begin
          addr_d  = w_dram_addr[AW+1:0];
          wdata_d = w_dram_wdata;
          ctrl_d  = w_dram_ctrl;
          store_d = w_dram_we_t;
          both_d  = w_dram_le & w_dram_we_t;
          cnt_d   = LAT_M1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = RD;
        else             cnt_d   = cnt_q - 8'd1;
      end
      RD:  state_d = FIN;
      FIN: begin
        if (!store_q) odata_d = load_data;
        err_d   = misalign | both_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      odata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ctrl_q  <= ctrl_d;
      store_q <= store_d;
      both_q  <= both_d;
      odata_q <= odata_d;
      err_q   <= err_d;
    end
  end

  // store commits only on leaving FIN, so a reset earlier discards it
  always_ff @(posedge CLK) begin
    if (state_q == RD) rdata_q <= mem[idx];
    if (state_q == FIN && store_q && !RST) mem[idx] <= store_word;
  end

  assign w_dram_busy  = (state_q != IDLE);
  assign w_dram_odata = odata_q;
  assign w_dram_err   = err_q;

endmodule

// File: tb/tb_dram_responder.sv
// Directed bench for dram_responder with LAT=2 (busy window of 4 cycles).
module tb_dram_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr, wdata;
  logic [2:0]  ctrl;
  logic        le, we;
  logic [31:0] odata;
  logic        busy, err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dram_responder #(.WORDS(1024), .LAT(2)) dut (
    .CLK          (clk),
    .RST          (rst),
    .w_dram_addr  (addr),
    .w_dram_wdata (wdata),
    .w_dram_ctrl  (ctrl),
    .w_dram_le    (le),
    .w_dram_we_t  (we),
    .w_dram_odata (odata),
    .w_dram_busy  (busy),
    .w_dram_err   (err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 50) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic txn(input string tag, input logic [31:0] a, input logic [31:0] d,
                     input logic [2:0] c, input logic l, input logic w,
                     input logic exp_err, input logic [31:0] exp_od);
    int n;
    @(negedge clk);
    addr = a; wdata = d; ctrl = c; le = l; we = w;
    @(negedge clk);
    le = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    wait_idle(n);
    check({tag, ".busy"}, n, 4);
    check({tag, ".err"}, err, exp_err);
    check({tag, ".od"}, odata, exp_od);
    @(negedge clk);
    check({tag, ".err_clr"}, err, 1'b0);
  endtask

  initial begin
    int n;
    rst = 1'b1; addr = '0; wdata = '0; ctrl = '0; le = 1'b0; we = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst.busy", busy, 1'b0);
    check("rst.err", err, 1'b0);
    check("rst.od", odata, 32'h0);

    txn("sw10",  32'h10, 32'hDEADBEEF, 3'b010, 1'b0, 1'b1, 1'b0, 32'h0);
    txn("lw10",  32'h10, 32'h0,        3'b010, 1'b1, 1'b0, 1'b0, 32'hDEADBEEF);
    txn("lb13",  32'h13, 32'h0,        3'b000, 1'b1, 1'b0, 1'b0, 32'hFFFFFFDE);
    txn("lbu13", 32'h13, 32'h0,        3'b100, 1'b1, 1'b0, 1'b0, 32'h000000DE);
    txn("lh12",  32'h12, 32'h0,        3'b001, 1'b1, 1'b0, 1'b0, 32'hFFFFDEAD);
    txn("lhu12", 32'h12, 32'h0,        3'b101, 1'b1, 1'b0, 1'b0, 32'h0000DEAD);
    txn("sb11",  32'h11, 32'h12345655, 3'b000, 1'b0, 1'b1, 1'b0, 32'h0000DEAD);
    txn("lw10b", 32'h10, 32'h0,        3'b010, 1'b1, 1'b0, 1'b0, 32'hDEAD55EF);
    txn("sh12",  32'h12, 32'hAAAA1234, 3'b001, 1'b0, 1'b1, 1'b0, 32'hDEAD55EF);
    txn("lw10c", 32'h10, 32'h0,        3'b010, 1'b1, 1'b0, 1'b0, 32'h123455EF);
    txn("lb10",  32'h10, 32'h0,        3'b000, 1'b1, 1'b0, 1'b0, 32'hFFFFFFEF);
    txn("lw12m", 32'h12, 32'h0,        3'b010, 1'b1, 1'b0, 1'b1, 32'h123455EF);
    txn("lh11m", 32'h11, 32'h0,        3'b001, 1'b1, 1'b0, 1'b1, 32'h000055EF);
    txn("lw11x", 32'h10, 32'h0,        3'b011, 1'b1, 1'b0, 1'b0, 32'h123455EF);
    txn("both",  32'h20, 32'h00000001, 3'b010, 1'b1, 1'b1, 1'b1, 32'h123455EF);
    txn("lw20",  32'h20, 32'h0,        3'b010, 1'b1, 1'b0, 1'b0, 32'h00000001);

    // le pulse during busy is dropped
    @(negedge clk);
    addr = 32'h10; ctrl = 3'b010; le = 1'b1;
    @(negedge clk);
    le = 1'b0;
    check("ign.b1", busy, 1'b1);
    @(negedge clk);
    check("ign.b2", busy, 1'b1);
    addr = 32'h20; le = 1'b1;
    @(negedge clk);
    le = 1'b0; addr = '0;
    wait_idle(n);
    check("ign.busy", n + 2, 4);
    check("ign.od", odata, 32'h123455EF);
    @(negedge clk);
    check("ign.noq", busy, 1'b0);

    // request held across busy fall starts the next transaction at once
    @(negedge clk);
    addr = 32'h20; ctrl = 3'b010; le = 1'b1;
    @(negedge clk);
    wait_idle(n);
    check("hold.busy1", n, 4);
    check("hold.od1", odata, 32'h00000001);
    @(negedge clk);
    check("hold.restart", busy, 1'b1);
    le = 1'b0; addr = '0;
    wait_idle(n);
    check("hold.busy2", n, 4);
    check("hold.od2", odata, 32'h00000001);

    // reset in WAIT discards a pending store
    txn("sw30z", 32'h30, 32'h0, 3'b010, 1'b0, 1'b1, 1'b0, 32'h00000001);
    @(negedge clk);
    addr = 32'h30; wdata = 32'hFFFFFFFF; ctrl = 3'b010; we = 1'b1;
    @(negedge clk);
    we = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstw.busy", busy, 1'b0);
    check("rstw.od", odata, 32'h0);
    txn("lw10r",  32'h10,   32'h0,        3'b010, 1'b1, 1'b0, 1'b0, 32'h123455EF);
    txn("lw30",   32'h30,   32'h0,        3'b010, 1'b1, 1'b0, 1'b0, 32'h0);
    txn("swal",   32'h1030, 32'h5A5A0001, 3'b010, 1'b0, 1'b1, 1'b0, 32'h0);
    txn("lw30al", 32'h30,   32'h0,        3'b010, 1'b1, 1'b0, 1'b0, 32'h5A5A0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
